multicycle_controller: RTL

//  Multi-cycle successor to the single-cycle RV32I control decoder. A Moore FSM

---
 rtl/rv32i_ctrl_pkg.sv | 46 ++++
 rtl/ctrl_wait_timer.sv | 48 ++++
 rtl/multicycle_controller.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rv32i_ctrl_pkg.sv
// rtl/rv32i_ctrl_pkg.sv - shared opcode, state and store-lane definitions for the multi-cycle controller
// Contents: RV32I opcode[6:2] constants, FSM state encoding, instruction class enum,
//           classify() opcode -> class, store_lanes() func3 -> 8-lane byte enable.
package rv32i_ctrl_pkg;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_IARITH = 5'b00100;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    typedef enum logic [2:0] {
        CLS_WB,      // R / I-arith / LUI / AUIPC / JAL / JALR: finish through WB
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_OTHER    // not one of the nine RV32I classes
    } instr_class_t;

    function automatic instr_class_t classify(input logic [4:0] op);
        case (op)
            OP_LOAD:   return CLS_LOAD;
            OP_STORE:  return CLS_STORE;
            OP_BRANCH: return CLS_BRANCH;
            OP_R, OP_IARITH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: return CLS_WB;
            default:   return CLS_OTHER;
        endcase
    endfunction

    // Lanes 7:4 only light up for SD; narrower configurations slice off the top.
    function automatic logic [7:0] store_lanes(input logic [2:0] f3);
        return {{4{f3 == 3'b011}}, {2{f3[1]}}, f3[0] | f3[1], 1'b1};
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// rtl/ctrl_wait_timer.sv - ready-wait counter with timeout detect for one req/ready handshake
// Ports: clk, rst (sync, active-high), req/ready (handshake being watched),
//        timeout (combinational: this cycle is one wait too many).
module ctrl_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ready,
    output logic timeout
);

    generate
        if (MAX_WAIT == 0) begin : g_no_timeout
            assign timeout = 1'b0;
        end else begin : g_timer
            localparam int CW = $clog2(MAX_WAIT + 1);
            localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

            logic [CW-1:0] count_q, count_d;

            // Any cycle without an outstanding wait (no req, or ready seen) restarts the count.
            // Holding at LIMIT keeps the counter from wrapping in the cycle that times out.
            always_comb begin
                count_d = count_q;
                if (!req || ready) begin
                    count_d = '0;
                end else if (count_q != LIMIT) begin
                    count_d = count_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            // MAX_WAIT not-ready cycles are tolerated; a ready arriving while the count sits at
            // LIMIT still completes the access.
            assign timeout = req && !ready && (count_q == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I control FSM with req/ready memory handshakes
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (trap unknown opcodes to HALT in DECODE).
// Ports: clk, rst (sync, active-high); opcode/func3/func7/aluOut_bit0 from IR and ALU;
//        im_ready/dm_ready from memories; im_req/dm_req/ir_en/pc_en/wb_en/dm_w_en strobes;
//        next_pc_sel/jb_op1_sel/alu_op1_sel/alu_op2_sel/wb_sel datapath selects;
//        opcode_out/func3_out/func7_out ALU pass-through; timeout_err/illegal_instr sticky
//        flags; state_o debug state. Every output reads 0 while rst is high.
module multicycle_controller
    import rv32i_ctrl_pkg::*;
#(
    parameter int DM_BYTES = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          opcode,
    input  logic [2:0]          func3,
    input  logic                func7,
    input  logic                aluOut_bit0,
    input  logic                im_ready,
    input  logic                dm_ready,
    output logic                im_req,
    output logic                dm_req,
    output logic                ir_en,
    output logic                pc_en,
    output logic                next_pc_sel,
    output logic                jb_op1_sel,
    output logic                alu_op1_sel,
    output logic                alu_op2_sel,
    output logic                wb_sel,
    output logic                wb_en,
    output logic [DM_BYTES-1:0] dm_w_en,
    output logic [4:0]          opcode_out,
    output logic [2:0]          func3_out,
    output logic                func7_out,
    output logic                timeout_err,
    output logic                illegal_instr,
    output logic [2:0]          state_o
);

    logic [2:0]    state_q, state_d;
    logic          timeout_q, timeout_d;
    logic          im_req_r, dm_req_r, ir_en_r, pc_en_r, wb_en_r;
    logic [DM_BYTES-1:0] w_en_r;
    logic          wait_timeout;
    logic [7:0]    lanes_all;
    instr_class_t  cls;

    assign cls       = classify(opcode);
    assign lanes_all = store_lanes(func3);

    ctrl_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .req     (im_req_r | dm_req_r),
        .ready   ((state_q == ST_MEM) ? dm_ready : im_ready),
        .timeout (wait_timeout)
    );

    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        im_req_r  = 1'b0;
        dm_req_r  = 1'b0;
        ir_en_r   = 1'b0;
        pc_en_r   = 1'b0;
        wb_en_r   = 1'b0;
        w_en_r    = '0;
        case (state_q)
            ST_FETCH: begin
                im_req_r = 1'b1;
                if (im_ready) begin
                    ir_en_r = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_timeout) begin
                    timeout_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_DECODE: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                state_d = (cls == CLS_OTHER) ? ST_HALT : ST_EXEC;
`else
                state_d = ST_EXEC;
`endif
            end
            ST_EXEC: begin
                case (cls)
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    CLS_WB:              state_d = ST_WB;
                    default: begin
                        // Branch resolves here; unknown opcodes retire as a NOP via pc+4.
                        pc_en_r = 1'b1;
                        state_d = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                dm_req_r = 1'b1;
                if (cls == CLS_STORE) begin
                    w_en_r = lanes_all[DM_BYTES-1:0];
                end
                if (dm_ready) begin
                    if (cls == CLS_STORE) begin
                        pc_en_r = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_timeout) begin
                    timeout_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_WB: begin
                wb_en_r = 1'b1;
                pc_en_r = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (state_q == ST_DECODE && cls == CLS_OTHER) begin
            illegal_q <= 1'b1;
        end
    end
    assign illegal_instr = ~rst & illegal_q;
`else
    assign illegal_instr = 1'b0;
`endif

    // Selects are pure opcode decode; branch target vs pc+4 follows the ALU compare.
    assign next_pc_sel = ~rst & ((opcode == OP_JAL || opcode == OP_JALR) ? 1'b0 :
                                 (opcode == OP_BRANCH) ? ~aluOut_bit0 : 1'b1);
    assign jb_op1_sel  = ~rst & (opcode != OP_JALR);
    assign alu_op1_sel = ~rst & (opcode == OP_LUI || opcode == OP_AUIPC ||
                                 opcode == OP_JAL || opcode == OP_JALR);
    assign alu_op2_sel = ~rst & (opcode != OP_R && opcode != OP_BRANCH);
    assign wb_sel      = ~rst & (opcode != OP_LOAD);

    assign im_req      = ~rst & im_req_r;
    assign dm_req      = ~rst & dm_req_r;
    assign ir_en       = ~rst & ir_en_r;
    assign pc_en       = ~rst & pc_en_r;
    assign wb_en       = ~rst & wb_en_r;
    assign dm_w_en     = {DM_BYTES{~rst}} & w_en_r;
    assign opcode_out  = {5{~rst}} & opcode;
    assign func3_out   = {3{~rst}} & func3;
    assign func7_out   = ~rst & func7;
    assign timeout_err = ~rst & timeout_q;
    assign state_o     = {3{~rst}} & state_q;

endmodule
